// File: rtl/ddr3_app_responder.sv
// DDR3 app_* responder: queues commands/write data, executes in order against on-chip RAM.
// Latency: write lands 1 cycle after pairing; read data READ_LATENCY+2 cycles after accept.
// Backpressure: app_rdy/app_wdf_rdy drop on full FIFOs or pseudo-random stalls (registered only).

// Small generic FIFO used for the command and write-data queues.
module ddr3_app_responder_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_100,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Storage needs no reset; occupancy gates what is visible.
  always_ff @(posedge clk_100) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
endmodule

module ddr3_app_responder #(
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_EN     = 0
) (
  input  logic         clk_100,
  input  logic         reset_n,
  input  logic [27:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [127:0] app_wdf_data,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         init_calib_complete,
  output logic         error
);
  localparam int CE_W  = 3 + ADDR_BITS;
  localparam int CNT_W = $clog2(CALIB_CYCLES + 1);

  logic [CNT_W-1:0] calib_cnt_q, calib_cnt_d;
  logic             calib_q, calib_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             error_q, error_d;
  logic             stall_c, stall_w;

  logic              cmd_push, cmd_pop, cmd_empty, cmd_full;
  logic [CE_W-1:0]   cmd_head;
  logic              wdf_push, wdf_pop, wdf_empty, wdf_full;
  logic [143:0]      wdf_head;
  logic [2:0]        head_cmd;
  logic [ADDR_BITS-1:0] head_addr;
  logic              head_wr, head_rd, head_bad, wr_go;

  logic [127:0]         ram_q [2**ADDR_BITS];
  logic                 rd_issue_vld_q;
  logic [ADDR_BITS-1:0] rd_issue_addr_q;
  logic                 ram_vld_q;
  logic [127:0]         ram_rd_q;
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [127:0]         pipe_dat_q [READ_LATENCY];
  logic                 unused_addr_hi;

  // Address bits above the RAM index alias and are deliberately ignored.
  assign unused_addr_hi = |app_addr[27:ADDR_BITS+3];

  assign stall_c = (STALL_EN != 0) && lfsr_q[0] && lfsr_q[1];
  assign stall_w = (STALL_EN != 0) && lfsr_q[2] && lfsr_q[3];

  assign app_rdy     = calib_q & ~cmd_full & ~stall_c;
  assign app_wdf_rdy = calib_q & ~wdf_full & ~stall_w;
  assign cmd_push    = app_en & app_rdy;
  assign wdf_push    = app_wdf_wren & app_wdf_rdy;

  ddr3_app_responder_fifo #(.W(CE_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk_100    (clk_100),
    .reset_n    (reset_n),
    .push_i     (cmd_push),
    .push_dat_i ({app_cmd, app_addr[ADDR_BITS+2:3]}),
    .pop_i      (cmd_pop),
    .head_dat_o (cmd_head),
    .empty_o    (cmd_empty),
    .full_o     (cmd_full)
  );

  ddr3_app_responder_fifo #(.W(144), .DEPTH(FIFO_DEPTH)) u_wdf_fifo (
    .clk_100    (clk_100),
    .reset_n    (reset_n),
    .push_i     (wdf_push),
    .push_dat_i ({app_wdf_data, app_wdf_mask}),
    .pop_i      (wdf_pop),
    .head_dat_o (wdf_head),
    .empty_o    (wdf_empty),
    .full_o     (wdf_full)
  );

  // In-order executor: a write waits for its data and blocks everything behind it.
  assign head_cmd  = cmd_head[CE_W-1 -: 3];
  assign head_addr = cmd_head[ADDR_BITS-1:0];
  assign head_wr   = ~cmd_empty & (head_cmd == 3'b000);
  assign head_rd   = ~cmd_empty & (head_cmd == 3'b001);
  assign head_bad  = ~cmd_empty & ~head_wr & ~head_rd;
  assign wr_go     = head_wr & ~wdf_empty;
  assign cmd_pop   = wr_go | head_rd | head_bad;
  assign wdf_pop   = wr_go;

  // Next-state for calibration counter, stall LFSR and sticky error.
  always_comb begin
    calib_cnt_d = calib_cnt_q;
    calib_d     = calib_q;
    if (!calib_q) begin
      calib_cnt_d = calib_cnt_q + 1'b1;
      if (calib_cnt_q == CNT_W'(CALIB_CYCLES - 1)) calib_d = 1'b1;
    end
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    error_d = error_q | head_bad | (cmd_push & (|app_addr[2:0]))
            | (calib_q & (app_wdf_wren ^ app_wdf_end));
  end

  // Control state registers.
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      calib_cnt_q <= '0;
      calib_q     <= 1'b0;
      lfsr_q      <= 16'hACE1;
      error_q     <= 1'b0;
    end else begin
      calib_cnt_q <= calib_cnt_d;
      calib_q     <= calib_d;
      lfsr_q      <= lfsr_d;
      error_q     <= error_d;
    end
  end

  // RAM: byte-masked write at execution, registered read one cycle after issue.
  always_ff @(posedge clk_100) begin
    if (wr_go && reset_n) begin
      for (int b = 0; b < 16; b++) begin
        if (!wdf_head[b]) ram_q[head_addr][8*b +: 8] <= wdf_head[16 + 8*b +: 8];
      end
    end
    if (rd_issue_vld_q) ram_rd_q <= ram_q[rd_issue_addr_q];
  end

  // Read return path: issue register, RAM register, then READ_LATENCY stages.
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      rd_issue_vld_q  <= 1'b0;
      rd_issue_addr_q <= '0;
      ram_vld_q       <= 1'b0;
      pipe_vld_q      <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_dat_q[i] <= '0;
    end else begin
      rd_issue_vld_q <= head_rd;
      if (head_rd) rd_issue_addr_q <= head_addr;
      ram_vld_q     <= rd_issue_vld_q;
      pipe_vld_q[0] <= ram_vld_q;
      pipe_dat_q[0] <= ram_vld_q ? ram_rd_q : 128'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  // Valid is masked by reset so in-flight beats vanish as soon as reset is asserted.
  assign app_rd_data         = pipe_dat_q[READ_LATENCY-1];
  assign app_rd_data_valid   = pipe_vld_q[READ_LATENCY-1] & reset_n;
  assign init_calib_complete = calib_q;
  assign error               = error_q;
endmodule

// File: tb/tb_ddr3_app_responder.sv
// Bench for ddr3_app_responder: one unstalled and one stalled instance share stimulus;
// sel chooses which instance handshakes and is observed. A transaction-level memory
// model (in-order command/data pairing) supplies every expected read beat.
module tb_ddr3_app_responder;
  typedef struct packed { logic [2:0] cmd; logic [27:0] addr; } cmd_t;
  typedef struct packed { logic [127:0] dat; logic [15:0] msk; } wd_t;

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic         reset_n = 1'b0;
  logic [27:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic         sel = 1'b0;

  logic d0_rdy, d0_wrdy, d0_rdv, d0_cal, d0_err;
  logic d1_rdy, d1_wrdy, d1_rdv, d1_cal, d1_err;
  logic [127:0] d0_rdd, d1_rdd;

  ddr3_app_responder #(.STALL_EN(0)) dut0 (
    .clk_100(clk_100), .reset_n(reset_n), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(d0_rdy), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(d0_wrdy), .app_rd_data(d0_rdd), .app_rd_data_valid(d0_rdv),
    .init_calib_complete(d0_cal), .error(d0_err));

  ddr3_app_responder #(.STALL_EN(1)) dut1 (
    .clk_100(clk_100), .reset_n(reset_n), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(d1_rdy), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(d1_wrdy), .app_rd_data(d1_rdd), .app_rd_data_valid(d1_rdv),
    .init_calib_complete(d1_cal), .error(d1_err));

  wire         rdy_s  = sel ? d1_rdy  : d0_rdy;
  wire         wrdy_s = sel ? d1_wrdy : d0_wrdy;
  wire         rdv_s  = sel ? d1_rdv  : d0_rdv;
  wire         cal_s  = sel ? d1_cal  : d0_cal;
  wire         err_s  = sel ? d1_err  : d0_err;
  wire [127:0] rdd_s  = sel ? d1_rdd  : d0_rdd;

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus queues, model state and observations.
  cmd_t sc_q[$];
  wd_t  sw_q[$];
  cmd_t mc_q[$];
  wd_t  mw_q[$];
  logic [127:0] mmem [1024];
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  int   gcyc_q[$];
  int   racc_q[$];
  int   wacc_last;

  always @(negedge clk_100) begin
    if (rdv_s === 1'b1) begin
      got_q.push_back(rdd_s);
      gcyc_q.push_back(cyc);
    end
  end

  // Model: commands execute strictly in accept order; a write consumes the oldest data.
  function automatic void model_drain();
    while (mc_q.size() > 0) begin
      int a;
      a = int'(mc_q[0].addr[12:3]);
      if (mc_q[0].cmd == 3'b000) begin
        if (mw_q.size() == 0) break;
        for (int b = 0; b < 16; b++)
          if (!mw_q[0].msk[b]) mmem[a][8*b +: 8] = mw_q[0].dat[8*b +: 8];
        void'(mw_q.pop_front());
      end else if (mc_q[0].cmd == 3'b001) begin
        exp_q.push_back(mmem[a]);
      end
      void'(mc_q.pop_front());
    end
  endfunction

  function automatic void clear_obs();
    got_q.delete(); gcyc_q.delete(); exp_q.delete(); racc_q.delete();
  endfunction

  // Drive queued commands/data (each after its start delay); record accepts into the model.
  task automatic run_stim(input int cmd_dly, input int wd_dly, input int budget);
    int n = 0;
    while ((sc_q.size() > 0 || sw_q.size() > 0) && n < budget) begin
      @(negedge clk_100);
      app_en       = (n >= cmd_dly) && (sc_q.size() > 0);
      app_wdf_wren = (n >= wd_dly) && (sw_q.size() > 0);
      app_wdf_end  = app_wdf_wren;
      if (app_en) begin app_cmd = sc_q[0].cmd; app_addr = sc_q[0].addr; end
      if (app_wdf_wren) begin app_wdf_data = sw_q[0].dat; app_wdf_mask = sw_q[0].msk; end
      if (app_en && rdy_s) begin
        if (sc_q[0].cmd == 3'b001) racc_q.push_back(cyc + 1);
        mc_q.push_back(sc_q.pop_front());
      end
      if (app_wdf_wren && wrdy_s) begin
        wacc_last = cyc + 1;
        mw_q.push_back(sw_q.pop_front());
      end
      model_drain();
      n++;
    end
    @(negedge clk_100);
    app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    vectors++;
    if (n >= budget) begin
      $display("FAIL stim_budget: %0d items left, required 0", sc_q.size() + sw_q.size());
      miscompares++;
      sc_q.delete(); sw_q.delete();
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t = 0;
    while (got_q.size() < n && t < budget) begin @(negedge clk_100); t++; end
    repeat (15) @(negedge clk_100);
  endtask

  task automatic do_reset();
    int t = 0;
    @(negedge clk_100);
    reset_n = 1'b0; app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    repeat (3) @(negedge clk_100);
    mc_q.delete(); mw_q.delete(); clear_obs();
    reset_n = 1'b1;
    while (cal_s !== 1'b1 && t < 200) begin @(negedge clk_100); t++; end
  endtask

  task automatic test_reset();
    int bad = 0;
    sel = 1'b0;
    @(negedge clk_100);
    reset_n = 1'b0;
    @(negedge clk_100);
    vectors++; if (d0_rdy !== 1'b0) begin $display("FAIL rst_app_rdy: got %b want 0", d0_rdy); miscompares++; end
    vectors++; if (d0_wrdy !== 1'b0) begin $display("FAIL rst_wdf_rdy: got %b want 0", d0_wrdy); miscompares++; end
    vectors++; if (d0_rdv !== 1'b0) begin $display("FAIL rst_rd_valid: got %b want 0", d0_rdv); miscompares++; end
    vectors++; if (d0_rdd !== 128'h0) begin $display("FAIL rst_rd_data: got %h want 0", d0_rdd); miscompares++; end
    vectors++; if (d0_cal !== 1'b0) begin $display("FAIL rst_calib: got %b want 0", d0_cal); miscompares++; end
    vectors++; if (d0_err !== 1'b0) begin $display("FAIL rst_error: got %b want 0", d0_err); miscompares++; end
    @(negedge clk_100);
    reset_n = 1'b1;
    // 63 edges after release: still calibrating, no ready anywhere.
    for (int i = 1; i < 64; i++) begin
      @(negedge clk_100);
      if (d0_cal !== 1'b0 || d0_rdy !== 1'b0 || d0_wrdy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin $display("FAIL calib_early: %0d cycles with calib/ready high, want 0", bad); miscompares++; end
    @(negedge clk_100);
    vectors++; if (d0_cal !== 1'b1) begin $display("FAIL calib_at_64: got %b want 1", d0_cal); miscompares++; end
    vectors++; if (d0_rdy !== 1'b1) begin $display("FAIL rdy_after_calib: got %b want 1", d0_rdy); miscompares++; end
  endtask

  task automatic test_back_to_back();
    cmd_t c; wd_t w; int bad = 0; int gaps = 0;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      c.cmd = 3'b000; c.addr = 28'(i << 3); sc_q.push_back(c);
      w.dat = 128'hdeadbeefabad1deaba53b411fadebabe + 128'(i); w.msk = '0; sw_q.push_back(w);
    end
    for (int i = 0; i < 256; i++) begin c.cmd = 3'b001; c.addr = 28'(i << 3); sc_q.push_back(c); end
    run_stim(0, 0, 2000);
    wait_beats(256, 600);
    vectors++;
    if (got_q.size() != 256) begin $display("FAIL b2b_count: got %0d want 256", got_q.size()); miscompares++; end
    for (int i = 0; i < got_q.size() && i < 256; i++) begin
      vectors++;
      if (got_q[i] !== 128'hdeadbeefabad1deaba53b411fadebabe + 128'(i) || got_q[i] !== exp_q[i]) begin
        bad++; miscompares++;
        if (bad < 5) $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() > 0 && racc_q.size() > 0) begin
      vectors++;
      if (gcyc_q[0] - racc_q[0] != 10) begin
        $display("FAIL b2b_latency: got %0d want 10", gcyc_q[0] - racc_q[0]); miscompares++;
      end
      for (int i = 1; i < gcyc_q.size(); i++) if (gcyc_q[i] - gcyc_q[i-1] != 1) gaps++;
      vectors++;
      if (gaps != 0) begin $display("FAIL b2b_rate: %0d gaps want 0", gaps); miscompares++; end
    end
  endtask

  task automatic test_masked_write();
    cmd_t c; wd_t w;
    clear_obs();
    c.addr = 28'h0;
    c.cmd = 3'b000; sc_q.push_back(c); sc_q.push_back(c);
    c.cmd = 3'b001; sc_q.push_back(c);
    w.dat = '1; w.msk = 16'h0000; sw_q.push_back(w);
    // Set mask bits protect bytes 0..7, so only the upper half takes the zeros.
    w.dat = '0; w.msk = 16'h00FF; sw_q.push_back(w);
    run_stim(0, 0, 100);
    wait_beats(1, 50);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 128'h0000000000000000FFFFFFFFFFFFFFFF || got_q[0] !== exp_q[0]) begin
      $display("FAIL masked_write: got %h (%0d beats) want %h",
               got_q.size() > 0 ? got_q[0] : 128'h0, got_q.size(), 128'h0000000000000000FFFFFFFFFFFFFFFF);
      miscompares++;
    end
  endtask

  task automatic test_data_cmd_order();
    cmd_t c; wd_t w;
    clear_obs();
    c.addr = 28'h38; c.cmd = 3'b000; sc_q.push_back(c); c.cmd = 3'b001; sc_q.push_back(c);
    w.dat = {$urandom, $urandom, $urandom, $urandom}; w.msk = '0; sw_q.push_back(w);
    run_stim(3, 0, 100);
    wait_beats(1, 50);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== w.dat) begin
      $display("FAIL data_first: got %h (%0d beats) want %h", got_q.size() > 0 ? got_q[0] : 128'h0, got_q.size(), w.dat);
      miscompares++;
    end
    clear_obs();
    c.addr = 28'h40; c.cmd = 3'b000; sc_q.push_back(c); c.cmd = 3'b001; sc_q.push_back(c);
    w.dat = {$urandom, $urandom, $urandom, $urandom}; sw_q.push_back(w);
    run_stim(0, 3, 100);
    wait_beats(1, 50);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== w.dat || got_q[0] !== exp_q[0]) begin
      $display("FAIL cmd_first: got %h (%0d beats) want %h", got_q.size() > 0 ? got_q[0] : 128'h0, got_q.size(), w.dat);
      miscompares++;
    end
    // Data at edge w -> write w+1 -> read issued w+2 -> RAM w+3 -> 8 stages.
    vectors++;
    if (gcyc_q.size() > 0 && gcyc_q[0] != wacc_last + 11) begin
      $display("FAIL cmd_first_wait: beat at %0d want %0d", gcyc_q[0], wacc_last + 11); miscompares++;
    end
  endtask

  task automatic test_stall();
    cmd_t c; wd_t w; int seen[$]; bit wr_seen[1024];
    logic [127:0] sum_got, sum_exp; int bad = 0;
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 1024; i++) wr_seen[i] = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      int a = int'($urandom_range(0, 1023));
      c.cmd = 3'b000; c.addr = {15'($urandom), 10'(a), 3'b000}; sc_q.push_back(c);
      w.dat = {$urandom, $urandom, $urandom, $urandom}; w.msk = '0; sw_q.push_back(w);
      if (!wr_seen[a]) begin wr_seen[a] = 1'b1; seen.push_back(a); end
    end
    for (int i = 0; i < 1024; i++) begin
      c.cmd = 3'b001; c.addr = {15'($urandom), 10'(seen[$urandom_range(0, seen.size() - 1)]), 3'b000};
      sc_q.push_back(c);
    end
    run_stim(0, 0, 30000);
    wait_beats(1024, 3000);
    vectors++;
    if (got_q.size() != 1024 || exp_q.size() != 1024) begin
      $display("FAIL stall_count: got %0d beats want %0d", got_q.size(), exp_q.size()); miscompares++;
    end
    sum_got = '0; sum_exp = '0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      sum_got += got_q[i]; sum_exp += exp_q[i];
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; miscompares++;
        if (bad < 5) $display("FAIL stall_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (sum_got !== sum_exp) begin $display("FAIL stall_checksum: got %h want %h", sum_got, sum_exp); miscompares++; end
    vectors++;
    if (d1_err !== 1'b0) begin $display("FAIL stall_error: got %b want 0", d1_err); miscompares++; end
  endtask

  task automatic test_errors();
    cmd_t c; int t = 0;
    sel = 1'b0;
    do_reset();
    c.cmd = 3'b010; c.addr = 28'h0; sc_q.push_back(c);
    run_stim(0, 0, 50);
    repeat (20) @(negedge clk_100);
    vectors++; if (d0_err !== 1'b1) begin $display("FAIL bad_cmd_error: got %b want 1", d0_err); miscompares++; end
    vectors++; if (got_q.size() != 0) begin $display("FAIL bad_cmd_beats: got %0d want 0", got_q.size()); miscompares++; end
    // Misaligned read still executes against word 0 and flags error.
    do_reset();
    c.cmd = 3'b001; c.addr = 28'h4; sc_q.push_back(c);
    run_stim(0, 0, 50);
    wait_beats(1, 50);
    vectors++; if (d0_err !== 1'b1) begin $display("FAIL misalign_error: got %b want 1", d0_err); miscompares++; end
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      $display("FAIL misalign_data: got %0d beats want 1 of %h", got_q.size(), exp_q.size() > 0 ? exp_q[0] : 128'h0);
      miscompares++;
    end
    // Reset in the middle of a read burst.
    clear_obs();
    for (int i = 0; i < 40; i++) begin c.cmd = 3'b001; c.addr = 28'(i << 3); sc_q.push_back(c); end
    run_stim(0, 0, 200);
    while (got_q.size() < 3 && t < 100) begin @(negedge clk_100); t++; end
    vectors++;
    if (rdv_s !== 1'b1) begin $display("FAIL burst_active: valid %b want 1", rdv_s); miscompares++; end
    reset_n = 1'b0;
    @(posedge clk_100); #1;
    vectors++; if (d0_rdv !== 1'b0) begin $display("FAIL reset_valid_drop: got %b want 0", d0_rdv); miscompares++; end
    vectors++; if (d0_err !== 1'b0) begin $display("FAIL reset_error_clear: got %b want 0", d0_err); miscompares++; end
    vectors++; if (d0_cal !== 1'b0) begin $display("FAIL reset_calib_restart: got %b want 0", d0_cal); miscompares++; end
    repeat (2) @(negedge clk_100);
    mc_q.delete(); mw_q.delete(); clear_obs();
    reset_n = 1'b1;
    repeat (80) @(negedge clk_100);
    vectors++; if (got_q.size() != 0) begin $display("FAIL reset_drop_reads: got %0d beats want 0", got_q.size()); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_masked_write();
    test_data_cmd_order();
    test_stall();
    test_errors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
